// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: data width and multiplier FSM state encodings.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;

    // Multiplier control states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

endpackage

// File: rtl/mbledhesi_ripple.sv
// WIDTH-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
// Ports:
//   a_i, b_i   WIDTH-bit addends
//   cin_i      carry into bit 0
//   sum_o      WIDTH-bit sum
//   cout_o     carry out of the MSB cell
module mbledhesi_ripple #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // Each cell owns its carry nets so the chain is a sequence of distinct signals
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_lsb
            assign c_in = cin_i;
        end else begin : g_chain
            assign c_in = g_fa[i-1].c_out;
        end

        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c_in;
        assign c_out    = (a_i[i] & b_i[i]) | (c_in & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = g_fa[WIDTH-1].c_out;

endmodule

// File: rtl/shumezuesi_sekuencial.sv
// Unsigned sequential shift-and-add multiplier, one partial product per clock.
// Ports:
//   CLK      clock, rising edge
//   RST      synchronous active-high reset, aborts any running operation
//   START    request, sampled only while idle
//   A, B     multiplicand / multiplier, captured on the accepting edge
//   BUSY     high while an operation is in progress
//   DONE     one-cycle pulse when PRODUCT carries a new result
//   PRODUCT  2*WIDTH-bit result, held until the next completion
module shumezuesi_sekuencial
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   PRODUCT
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     mq_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic [2*WIDTH-1:0]   shift_d;
    logic [WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]     mq_d;

    // Partial product selected by the current multiplier LSB
    assign addend = mq_q[0] ? mcand_q : '0;

    mbledhesi_ripple #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // {C,SUM,MQ} shifted right once; the consumed MQ LSB falls off, carry enters the top
    assign shift_d = {cout, sum, mq_q[WIDTH-1:1]};
    assign acc_d   = shift_d[2*WIDTH-1:WIDTH];
    assign mq_d    = shift_d[WIDTH-1:0];

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        mcand_q <= A;
                        acc_q   <= '0;
                        mq_q    <= B;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        product_q <= shift_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PRODUCT = product_q;

endmodule

// File: tb/tb_shumezuesi_sekuencial.sv
// Bench for shumezuesi_sekuencial: directed scenarios plus random traffic, all
// checked each cycle against a latency/arithmetic model of the multiplier.
module tb_shumezuesi_sekuencial;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned LAT   = WIDTH;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    int errors = 0;
    int checks = 0;

    shumezuesi_sekuencial #(
        .WIDTH (WIDTH)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .START   (start),
        .A       (a),
        .B       (b),
        .BUSY    (busy),
        .DONE    (done),
        .PRODUCT (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: result is A*B, appearing a fixed LAT edges after acceptance
    logic               m_busy = 1'b0;
    logic               m_done = 1'b0;
    logic [2*WIDTH-1:0] m_prod = '0;
    logic [2*WIDTH-1:0] m_pend = '0;
    int                 m_rem  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_rem  <= LAT;
                    m_pend <= (2*WIDTH)'(a) * (2*WIDTH)'(b);
                end
            end else if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_prod <= m_pend;
                m_rem  <= 0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("product", 64'(product), 64'(m_prod));
    end

    // Wait (bounded) for DONE; lat counts negedges from the call point
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 3 * LAT) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) chk("done_timeout", 64'(done), 64'(1));
    endtask

    // Issue one single-cycle START and wait for completion, returning latency
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, output int lat);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int n_done;

        // 1: reset held two cycles with START asserted
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'd5;
        b     = 16'd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_product", 64'(product), 64'(0));
        end
        rst   = 1'b0;
        start = 1'b0;

        // 2: 3*5, latency and busy length
        run_op(16'd3, 16'd5, lat);
        chk("lat_3x5", 64'(lat), 64'(LAT));
        chk("prod_3x5", 64'(product), 64'h0000_000F);
        @(negedge clk);
        chk("done_pulse_once", 64'(done), 64'(0));

        // 3: full-scale operands
        run_op(16'hFFFF, 16'hFFFF, lat);
        chk("prod_ffff", 64'(product), 64'hFFFE_0001);

        // 4: START while busy ignored, START on DONE cycle accepted
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h0010;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; a = 16'd9; b = 16'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("prod_1234", 64'(product), 64'h0001_2340);
        start = 1'b1; a = 16'd7; b = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("done_drop", 64'(done), 64'(0));
        chk("busy_back2back", 64'(busy), 64'(1));
        wait_done(lat);
        chk("lat_back2back", 64'(lat), 64'(LAT));
        chk("prod_7x0", 64'(product), 64'h0);

        // 5: reset after 8 CALC cycles aborts, then a fresh operation
        @(negedge clk);
        start = 1'b1; a = 16'd2; b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_product", 64'(product), 64'h0);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'(0));
        run_op(16'd6, 16'd7, lat);
        chk("prod_6x7", 64'(product), 64'h0000_002A);

        // 6: operand inputs wiggle during CALC, then product held while idle
        @(negedge clk);
        start = 1'b1; a = 16'h00FF; b = 16'h0101;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 3 * LAT) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("lat_wiggle", 64'(lat), 64'(LAT));
        chk("prod_wiggle", 64'(product), 64'h0000_FFFF);
        repeat (20) @(negedge clk);
        chk("prod_held", 64'(product), 64'h0000_FFFF);

        // Random traffic: random START, operands and occasional reset
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a     = 16'($urandom);
            b     = 16'($urandom);
            rst   = ($urandom_range(0, 199) == 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
